// File: rtl/if_stage.sv
// Instruction-fetch front end: drives fetch PC, issues aligned pair requests to the
// i-cache, tracks in-flight requests by epoch and delivers registered pairs to decode.
module if_stage #(
    parameter logic [31:0] RESET_PC     = 32'h1c000000,
    parameter int unsigned MAX_INFLIGHT = 2,
    parameter logic [6:0]  EXP_ADEF     = 7'h08
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush,
    input  logic [31:0] flush_target,
    input  logic        set_pc,
    input  logic [31:0] set_pc_target,
    input  logic        id_full,
    output logic [31:0] bp_pc,
    input  logic [31:0] bp_next_pc,
    input  logic        bp_first_jmp,
    output logic        ic_req_valid,
    output logic [31:0] ic_req_addr,
    input  logic        ic_req_ready,
    input  logic        ic_resp_valid,
    input  logic [63:0] ic_resp_data,
    input  logic [6:0]  ic_resp_exception,
    output logic        out_valid,
    output logic [31:0] inst0,
    output logic [31:0] inst1,
    output logic [31:0] pc_out,
    output logic [31:0] pc_next_out,
    output logic        first_inst_jmp,
    output logic [6:0]  exception_out,
    output logic [31:0] badv_out
);
    localparam int unsigned PW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int unsigned CW = $clog2(MAX_INFLIGHT + 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] next;
        logic        first_jmp;
        logic [1:0]  epoch;
        logic        adef;
    } entry_t;

    logic [31:0]   pc_q, pc_d;
    logic [1:0]    epoch_q, epoch_d;
    logic          halt_q, halt_d;
    entry_t        fifo_q [MAX_INFLIGHT];
    entry_t        fifo_d [MAX_INFLIGHT];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          out_valid_q, out_valid_d;
    logic [31:0]   inst0_q, inst0_d;
    logic [31:0]   inst1_q, inst1_d;
    logic [31:0]   pc_out_q, pc_out_d;
    logic [31:0]   pc_next_out_q, pc_next_out_d;
    logic          first_inst_jmp_q, first_inst_jmp_d;
    logic [6:0]    exception_out_q, exception_out_d;
    logic [31:0]   badv_out_q, badv_out_d;

    logic   redirect, has_room, fire, adef_push, push, pop;
    entry_t head, new_entry;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_INFLIGHT - 1)) ? '0 : p + 1'b1;
    endfunction

    assign redirect     = flush | set_pc;
    assign has_room     = cnt_q < CW'(MAX_INFLIGHT);
    assign ic_req_valid = ~id_full & ~redirect & has_room & (pc_q[1:0] == 2'b00);
    assign fire         = ic_req_valid & ic_req_ready;
    // A misaligned PC queues one exception-only entry, then fetch parks until a redirect.
    assign adef_push    = ~id_full & ~redirect & has_room & (pc_q[1:0] != 2'b00) & ~halt_q;
    assign push         = fire | adef_push;
    assign head         = fifo_q[rd_ptr_q];
    assign pop          = (cnt_q != '0) & (head.adef | ic_resp_valid);

    assign bp_pc       = pc_q;
    assign ic_req_addr = {pc_q[31:3], 3'b000};

    always_comb begin
        new_entry.pc        = pc_q;
        new_entry.next      = bp_next_pc;
        new_entry.first_jmp = bp_first_jmp & ~pc_q[2] & ~adef_push;
        new_entry.epoch     = epoch_q;
        new_entry.adef      = adef_push;
    end

    always_comb begin
        pc_d    = pc_q;
        epoch_d = epoch_q;
        halt_d  = halt_q;
        if (flush) begin
            pc_d    = flush_target;
            epoch_d = epoch_q + 2'd1;
            halt_d  = 1'b0;
        end else if (set_pc) begin
            pc_d    = set_pc_target;
            epoch_d = epoch_q + 2'd1;
            halt_d  = 1'b0;
        end else begin
            if (fire) pc_d = bp_next_pc;
            if (adef_push) halt_d = 1'b1;
        end
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            fifo_d[wr_ptr_q] = new_entry;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end
        if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    always_comb begin
        out_valid_d      = 1'b0;
        inst0_d          = inst0_q;
        inst1_d          = inst1_q;
        pc_out_d         = pc_out_q;
        pc_next_out_d    = pc_next_out_q;
        first_inst_jmp_d = first_inst_jmp_q;
        exception_out_d  = exception_out_q;
        badv_out_d       = badv_out_q;
        if (pop) begin
            // Entries from an older epoch, or popping during a redirect, are dropped silently.
            out_valid_d      = (head.epoch == epoch_q) & ~redirect;
            pc_out_d         = head.pc;
            pc_next_out_d    = head.next;
            first_inst_jmp_d = head.first_jmp;
            if (head.adef) begin
                inst0_d         = '0;
                inst1_d         = '0;
                exception_out_d = EXP_ADEF;
                badv_out_d      = head.pc;
            end else begin
                inst0_d         = ic_resp_data[31:0];
                inst1_d         = ic_resp_data[63:32];
                exception_out_d = ic_resp_exception;
                badv_out_d      = (ic_resp_exception != '0) ? {head.pc[31:3], 3'b000} : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pc_q             <= RESET_PC;
            epoch_q          <= '0;
            halt_q           <= 1'b0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            cnt_q            <= '0;
            for (int unsigned i = 0; i < MAX_INFLIGHT; i++) fifo_q[i] <= '0;
            out_valid_q      <= 1'b0;
            inst0_q          <= '0;
            inst1_q          <= '0;
            pc_out_q         <= '0;
            pc_next_out_q    <= '0;
            first_inst_jmp_q <= 1'b0;
            exception_out_q  <= '0;
            badv_out_q       <= '0;
        end else begin
            pc_q             <= pc_d;
            epoch_q          <= epoch_d;
            halt_q           <= halt_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            cnt_q            <= cnt_d;
            fifo_q           <= fifo_d;
            out_valid_q      <= out_valid_d;
            inst0_q          <= inst0_d;
            inst1_q          <= inst1_d;
            pc_out_q         <= pc_out_d;
            pc_next_out_q    <= pc_next_out_d;
            first_inst_jmp_q <= first_inst_jmp_d;
            exception_out_q  <= exception_out_d;
            badv_out_q       <= badv_out_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign inst0          = inst0_q;
    assign inst1          = inst1_q;
    assign pc_out         = pc_out_q;
    assign pc_next_out    = pc_next_out_q;
    assign first_inst_jmp = first_inst_jmp_q;
    assign exception_out  = exception_out_q;
    assign badv_out       = badv_out_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: small i-cache and predictor models, delivered pairs and
// issued requests are logged and compared against hand-computed values.
module tb_if_stage;
    logic        clk;
    logic        rstn;
    logic        flush;
    logic [31:0] flush_target;
    logic        set_pc;
    logic [31:0] set_pc_target;
    logic        id_full;
    logic [31:0] bp_pc;
    logic [31:0] bp_next_pc;
    logic        bp_first_jmp;
    logic        ic_req_valid;
    logic [31:0] ic_req_addr;
    logic        ic_req_ready;
    logic        ic_resp_valid = 1'b0;
    logic [63:0] ic_resp_data = '0;
    logic [6:0]  ic_resp_exception = '0;
    logic        out_valid;
    logic [31:0] inst0;
    logic [31:0] inst1;
    logic [31:0] pc_out;
    logic [31:0] pc_next_out;
    logic        first_inst_jmp;
    logic [6:0]  exception_out;
    logic [31:0] badv_out;

    logic        ic_stall;
    logic        jmp_en;
    logic [31:0] jmp_pc;
    logic [31:0] jmp_tgt;
    logic [31:0] exc_addr;
    logic [31:0] cyc = '0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] nx;
        logic [31:0] i0;
        logic [31:0] i1;
        logic [31:0] badv;
        logic [6:0]  exc;
        logic        jmp;
        logic [31:0] cyc;
    } rec_t;

    rec_t        rec_q[$];
    logic [31:0] req_q[$];
    logic [31:0] icq[$];

    int n_checks = 0;
    int n_errors = 0;

    if_stage #(.RESET_PC(32'h1c000000), .MAX_INFLIGHT(2), .EXP_ADEF(7'h08)) dut (
        .clk(clk), .rstn(rstn), .flush(flush), .flush_target(flush_target),
        .set_pc(set_pc), .set_pc_target(set_pc_target), .id_full(id_full),
        .bp_pc(bp_pc), .bp_next_pc(bp_next_pc), .bp_first_jmp(bp_first_jmp),
        .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
        .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
        .ic_resp_exception(ic_resp_exception), .out_valid(out_valid), .inst0(inst0),
        .inst1(inst1), .pc_out(pc_out), .pc_next_out(pc_next_out),
        .first_inst_jmp(first_inst_jmp), .exception_out(exception_out), .badv_out(badv_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sequential predictor unless the configured jump PC is presented.
    always_comb begin
        bp_next_pc   = {bp_pc[31:3] + 29'd1, 3'b000};
        bp_first_jmp = 1'b0;
        if (jmp_en && bp_pc == jmp_pc) begin
            bp_next_pc   = jmp_tgt;
            bp_first_jmp = 1'b1;
        end
    end

    // I-cache: one-cycle in-order responses, data = {addr+4, addr}; stall holds responses.
    always @(posedge clk) begin
        cyc = cyc + 32'd1;
        if (ic_resp_valid) begin
            assert (icq.size() > 0) else $error("i-cache response with nothing outstanding");
            if (icq.size() > 0) void'(icq.pop_front());
        end
        if (ic_req_valid && ic_req_ready) begin
            icq.push_back(ic_req_addr);
            req_q.push_back(ic_req_addr);
        end
        #1;
        if (out_valid)
            rec_q.push_back({pc_out, pc_next_out, inst0, inst1, badv_out, exception_out,
                             first_inst_jmp, cyc});
        if (!ic_stall && icq.size() > 0) begin
            ic_resp_valid     = 1'b1;
            ic_resp_data      = {icq[0] + 32'd4, icq[0]};
            ic_resp_exception = (icq[0] == exc_addr) ? 7'h0c : 7'h00;
        end else begin
            ic_resp_valid     = 1'b0;
            ic_resp_data      = '0;
            ic_resp_exception = '0;
        end
    end

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic expect_pair(input string tag, input int idx, input logic [31:0] pc,
                               input logic [31:0] nx, input logic jmp);
        rec_t r;
        r = '0;
        if (idx < rec_q.size()) r = rec_q[idx];
        check32({tag, ".pc"}, r.pc, pc);
        check32({tag, ".nx"}, r.nx, nx);
        check32({tag, ".jmp"}, {31'd0, r.jmp}, {31'd0, jmp});
    endtask

    function automatic logic [31:0] req_at(input int idx);
        return (idx < req_q.size()) ? req_q[idx] : 32'hdeadbeef;
    endfunction

    function automatic rec_t rec_at(input int idx);
        return (idx < rec_q.size()) ? rec_q[idx] : '0;
    endfunction

    task automatic run_free(input int n);
        id_full = 1'b0;
        repeat (n) @(negedge clk);
        id_full = 1'b1;
    endtask

    task automatic drain();
        repeat (6) @(negedge clk);
    endtask

    task automatic redirect(input logic f, input logic [31:0] ft, input logic s,
                            input logic [31:0] st);
        flush = f; flush_target = ft; set_pc = s; set_pc_target = st;
        @(negedge clk);
        flush = 1'b0; set_pc = 1'b0;
    endtask

    task automatic clear_logs();
        rec_q.delete();
        req_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; flush = 1'b0; flush_target = '0; set_pc = 1'b0; set_pc_target = '0;
        id_full = 1'b1; ic_req_ready = 1'b1; ic_stall = 1'b0;
        jmp_en = 1'b0; jmp_pc = '0; jmp_tgt = '0; exc_addr = 32'hfffffff8;
        repeat (3) @(negedge clk);
        check32("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check32("rst_pc_out", pc_out, 32'd0);
        check32("rst_bp_pc", bp_pc, 32'h1c000000);
        check32("rst_ic_addr", ic_req_addr, 32'h1c000000);
        check32("rst_exc", {25'd0, exception_out}, 32'd0);
        check32("rst_badv", badv_out, 32'd0);
        rstn = 1'b1;

        // Sequential streaming
        clear_logs();
        run_free(3);
        drain();
        check32("s1_nreq", req_q.size(), 32'd3);
        check32("s1_req0", req_at(0), 32'h1c000000);
        check32("s1_req1", req_at(1), 32'h1c000008);
        check32("s1_req2", req_at(2), 32'h1c000010);
        check32("s1_nrec", rec_q.size(), 32'd3);
        expect_pair("s1_p0", 0, 32'h1c000000, 32'h1c000008, 1'b0);
        expect_pair("s1_p1", 1, 32'h1c000008, 32'h1c000010, 1'b0);
        expect_pair("s1_p2", 2, 32'h1c000010, 32'h1c000018, 1'b0);
        check32("s1_i0", rec_at(1).i0, 32'h1c000008);
        check32("s1_i1", rec_at(1).i1, 32'h1c00000c);
        check32("s1_exc", {25'd0, rec_at(0).exc}, 32'd0);
        check32("s1_badv", rec_at(0).badv, 32'd0);
        check32("s1_back2back", rec_at(2).cyc - rec_at(0).cyc, 32'd2);

        // Predicted taken jump in slot 0
        clear_logs();
        jmp_en = 1'b1; jmp_pc = 32'h1c000000; jmp_tgt = 32'h1c000100;
        redirect(1'b1, 32'h1c000000, 1'b0, '0);
        run_free(2);
        drain();
        jmp_en = 1'b0;
        check32("s2_req0", req_at(0), 32'h1c000000);
        check32("s2_req1", req_at(1), 32'h1c000100);
        expect_pair("s2_p0", 0, 32'h1c000000, 32'h1c000100, 1'b1);
        expect_pair("s2_p1", 1, 32'h1c000100, 32'h1c000108, 1'b0);

        // id_full stall with two outstanding
        clear_logs();
        ic_stall = 1'b1;
        run_free(2);
        ic_stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check32("s3_hold_noreq", {31'd0, ic_req_valid}, 32'd0);
        end
        check32("s3_delivered_in_hold", rec_q.size(), 32'd2);
        id_full = 1'b0;
        #1;
        check32("s3_resume_valid", {31'd0, ic_req_valid}, 32'd1);
        check32("s3_resume_addr", ic_req_addr, 32'h1c000118);
        @(negedge clk);
        id_full = 1'b1;
        drain();
        check32("s3_nreq", req_q.size(), 32'd3);
        expect_pair("s3_p0", 0, 32'h1c000108, 32'h1c000110, 1'b0);
        expect_pair("s3_p1", 1, 32'h1c000110, 32'h1c000118, 1'b0);
        expect_pair("s3_p2", 2, 32'h1c000118, 32'h1c000120, 1'b0);

        // set_pc with two requests in flight
        clear_logs();
        ic_stall = 1'b1;
        run_free(2);
        redirect(1'b0, '0, 1'b1, 32'h1c000040);
        ic_stall = 1'b0;
        drain();
        check32("s4_stale_suppressed", rec_q.size(), 32'd0);
        run_free(2);
        drain();
        check32("s4_nreq", req_q.size(), 32'd4);
        check32("s4_req2", req_at(2), 32'h1c000040);
        expect_pair("s4_p0", 0, 32'h1c000040, 32'h1c000048, 1'b0);
        expect_pair("s4_p1", 1, 32'h1c000048, 32'h1c000050, 1'b0);

        // flush beats set_pc
        clear_logs();
        redirect(1'b1, 32'h1c008000, 1'b1, 32'h1c000040);
        run_free(1);
        drain();
        check32("s5_nreq", req_q.size(), 32'd1);
        check32("s5_req0", req_at(0), 32'h1c008000);
        expect_pair("s5_p0", 0, 32'h1c008000, 32'h1c008008, 1'b0);

        // Misaligned flush target
        clear_logs();
        redirect(1'b1, 32'h1c000006, 1'b0, '0);
        run_free(4);
        drain();
        check32("s6_nreq", req_q.size(), 32'd0);
        check32("s6_nrec", rec_q.size(), 32'd1);
        check32("s6_pc", rec_at(0).pc, 32'h1c000006);
        check32("s6_exc", {25'd0, rec_at(0).exc}, 32'h08);
        check32("s6_badv", rec_at(0).badv, 32'h1c000006);
        check32("s6_pc_held", bp_pc, 32'h1c000006);
        id_full = 1'b0;
        #1;
        check32("s6_halted", {31'd0, ic_req_valid}, 32'd0);
        @(negedge clk);
        id_full = 1'b1;
        drain();
        check32("s6_single_entry", rec_q.size(), 32'd1);

        // I-cache exception on an odd-slot fetch; slot-0 jump bit must be masked
        clear_logs();
        jmp_en = 1'b1; jmp_pc = 32'h1c00000c; jmp_tgt = 32'h1c000200;
        exc_addr = 32'h1c000008;
        redirect(1'b1, 32'h1c00000c, 1'b0, '0);
        run_free(1);
        drain();
        jmp_en = 1'b0;
        check32("s7_req0", req_at(0), 32'h1c000008);
        expect_pair("s7_p0", 0, 32'h1c00000c, 32'h1c000200, 1'b0);
        check32("s7_i0", rec_at(0).i0, 32'h1c000008);
        check32("s7_i1", rec_at(0).i1, 32'h1c00000c);
        check32("s7_exc", {25'd0, rec_at(0).exc}, 32'h0c);
        check32("s7_badv", rec_at(0).badv, 32'h1c000008);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
